flux_rr_scheduler: RTL and testbench
====================================

Name: flux_rr_scheduler

Overview:
- Round-robin scheduler for the multi-flux actor datapath. Each actor time-multiplexes FLUX tagged streams and keeps per-flux state in a dual-ported RAM indexed by tag.
- Picks the flux served each cycle, drives the one-hot input read strobes and emits the grant tag.
- Sequences a post-reset clear of the per-flux state RAM so every flux starts from zero data.
- Sits between the actor's FIFO status/read lines and its datapath; replaces fixed lowest-index priority with fair rotation.

Parameters:
FLUX, 2, number of multiplexed streams; must be >= 2
DATA_WIDTH, 18, width of the per-flux state word cleared during init
TAG_WIDTH, $clog2(FLUX), flux tag width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_empty  in  FLUX  per-flux input FIFO empty
out_full  in  FLUX  per-flux output FIFO full
flush  in  1  request to re-run the RAM clear sequence
in_read  out  FLUX  one-hot read strobe to input FIFOs
grant_valid  out  1  a flux is served this cycle (write strobe to output FIFO)
grant_tag  out  TAG_WIDTH  served flux; RAM read/write address and output tag
mem_init_we  out  1  state-RAM write enable during clear
mem_init_addr  out  TAG_WIDTH  state-RAM address during clear
mem_init_data  out  DATA_WIDTH  constant zero
init_done  out  1  high in RUN state

Behaviour:
- Eligibility: eligible[i] = !in_empty[i] & !out_full[i].
- States: INIT, RUN. Registers: state, init_addr, rr_ptr.
- Reset (rst=1 at an edge): state<=INIT, init_addr<=0, rr_ptr<=0.
- While rst is high, all outputs are forced to 0: in_read, grant_valid, grant_tag, mem_init_we, mem_init_addr, init_done.
- INIT:
  - mem_init_we=1, mem_init_addr=init_addr, mem_init_data=0.
  - grant_valid=0, in_read=0, init_done=0.
  - init_addr increments each cycle.
  - At init_addr==FLUX-1: next state RUN and init_addr<=0.
  - INIT lasts exactly FLUX cycles.
- RUN:
  - mem_init_we=0, init_done=1.
  - Grant is combinational, zero latency, in the same cycle as eligibility.
  - Search starts at rr_ptr and wraps modulo FLUX. The first eligible index becomes grant_tag; grant_valid=1; in_read[grant_tag]=1, all other bits 0.
  - No eligible flux: grant_valid=0, in_read=0, grant_tag=0, rr_ptr unchanged.
  - On grant: rr_ptr<=(grant_tag+1) mod FLUX. Wrap from FLUX-1 to 0 is explicit; no reliance on power-of-two FLUX.
- flush:
  - Sampled in RUN. flush=1 makes the next state INIT with init_addr<=0; rr_ptr is preserved.
  - Any grant in the flush cycle still completes.
  - flush during INIT is ignored; the sequence is not restarted.
- rst asserted mid-INIT or mid-RUN: restarts INIT from address 0 on the next edge.
- Eligibility may change every cycle; there is no grant hold across cycles (single-token actors).
- At most one in_read bit is high in any cycle. in_read is never asserted for an ineligible flux.

Optional Feature:
- Macro FLUX_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt, width FLUX*16, flat vector, slice i = flux i.
  - Adds input cnt_clr.
  - Per-flux 16-bit grant counters increment on each grant to that flux and saturate at 16'hFFFF.
  - Cleared by rst or by cnt_clr=1 (cnt_clr wins over a simultaneous increment).
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Shared package flux_sched_pkg:
  - state enum typedef (INIT, RUN)
  - localparam CNT_WIDTH=16
  - function next_tag(ptr, FLUX) returning (ptr+1) mod FLUX
- One sub-module: flux_rr_pick.
  - Purely combinational rotate-and-priority-select.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: valid and tag.
  - Reusable by other multi-flux actors.
- Scheduler top holds the FSM, pointer and optional counters.

Test Plan:
- FLUX=4, reset released:
  - mem_init_we high for exactly 4 cycles, mem_init_addr 0,1,2,3, mem_init_data 0.
  - grant_valid 0 throughout; init_done rises on cycle 5.
- RUN, all four flux eligible every cycle -> grant_tag sequence 0,1,2,3,0,1; in_read 0001,0010,0100,1000 repeating.
- RUN, rr_ptr=2, only flux 1 and 3 eligible -> grant_tag=3; next cycle with same eligibility grant_tag=1, then 3 (wrap through 0).
- out_full[2]=1 with in_empty[2]=0, others empty -> grant_valid=0, in_read=0000, rr_ptr unchanged.
- rst asserted at INIT address 2 -> next cycle mem_init_addr=0; full 4-cycle clear repeats. flush in RUN -> INIT re-entered, rr_ptr preserved across the clear.
- FLUX_GRANT_CNT_EN defined:
  - 70000 grants to flux 0 -> grant_cnt slice 0 = 16'hFFFF.
  - cnt_clr pulse -> all slices 0, even with a grant in the same cycle.

Source files
------------

// File: rtl/flux_sched_pkg.sv
// Shared types and helpers for the multi-flux round-robin scheduler.
// Optional per-flux grant counters are built only when FLUX_GRANT_CNT_EN is defined.
package flux_sched_pkg;

    // Scheduler phases: clear the per-flux state RAM, then serve fluxes
    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } flux_state_e;

    localparam int unsigned CNT_WIDTH = 16;

    // Successor of a flux tag. The wrap is explicit, so any FLUX >= 2 works.
    function automatic int unsigned next_tag(input int unsigned ptr, input int unsigned flux);
        if (ptr + 1 >= flux) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/flux_rr_pick.sv
// Combinational rotate-and-priority select. Scans from ptr_i upward, wrapping
// modulo FLUX, and returns the first eligible index. Reusable by any multi-flux actor.
module flux_rr_pick #(
    parameter int unsigned FLUX      = 2,
    parameter int unsigned TAG_WIDTH = $clog2(FLUX)
) (
    input  logic [FLUX-1:0]      eligible_i,
    input  logic [TAG_WIDTH-1:0] ptr_i,
    output logic                 valid_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    // First eligible flux at or after the pointer, wrapping past FLUX-1 to 0
    always_comb begin
        int unsigned           sum;
        logic [TAG_WIDTH-1:0]  idx;
        logic                  found;
        valid_o = 1'b0;
        tag_o   = '0;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int unsigned k = 0; k < FLUX; k++) begin
            sum = 32'(ptr_i) + k;
            if (sum >= FLUX) begin
                sum = sum - FLUX;
            end
            idx = sum[TAG_WIDTH-1:0];
            if (!found && eligible_i[idx]) begin
                found = 1'b1;
                tag_o = idx;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin flux scheduler: clears the per-flux state RAM after reset or flush,
// then grants one eligible flux per cycle with fair rotation.
// Define FLUX_GRANT_CNT_EN to add saturating per-flux grant counters (grant_cnt_o, cnt_clr_i).
module flux_rr_scheduler
    import flux_sched_pkg::*;
#(
    parameter  int unsigned FLUX       = 2,
    parameter  int unsigned DATA_WIDTH = 18,
    localparam int unsigned TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [FLUX-1:0]           in_empty_i,
    input  logic [FLUX-1:0]           out_full_i,
    input  logic                      flush_i,
`ifdef FLUX_GRANT_CNT_EN
    input  logic                      cnt_clr_i,
    output logic [FLUX*CNT_WIDTH-1:0] grant_cnt_o,
`endif
    output logic [FLUX-1:0]           in_read_o,
    output logic                      grant_valid_o,
    output logic [TAG_WIDTH-1:0]      grant_tag_o,
    output logic                      mem_init_we_o,
    output logic [TAG_WIDTH-1:0]      mem_init_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_init_data_o,
    output logic                      init_done_o
);

    flux_state_e          state_q, state_d;
    logic [TAG_WIDTH-1:0] init_addr_q, init_addr_d;
    logic [TAG_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [FLUX-1:0]      eligible;
    logic                 pick_valid;
    logic [TAG_WIDTH-1:0] pick_tag;
    logic                 in_run;
    logic                 in_init;

    assign eligible = ~in_empty_i & ~out_full_i;

    flux_rr_pick #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .valid_o    (pick_valid),
        .tag_o      (pick_tag)
    );

    // Reset overrides every output, even though state only changes at the edge
    assign in_run  = (state_q == StRun) && !rst_i;
    assign in_init = (state_q == StInit) && !rst_i;

    // Next-state: INIT walks every RAM address once; RUN advances the pointer past each grant
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        rr_ptr_d    = rr_ptr_q;
        unique case (state_q)
            StInit: begin
                // flush is deliberately ignored here so a clear is never restarted
                if (init_addr_q == TAG_WIDTH'(FLUX - 1)) begin
                    state_d     = StRun;
                    init_addr_d = '0;
                end else begin
                    init_addr_d = init_addr_q + 1'b1;
                end
            end
            StRun: begin
                // A grant in the flush cycle still completes and moves the pointer
                if (pick_valid) begin
                    rr_ptr_d = TAG_WIDTH'(next_tag(32'(pick_tag), FLUX));
                end
                if (flush_i) begin
                    state_d     = StInit;
                    init_addr_d = '0;
                end
            end
            default: begin
                state_d     = StInit;
                init_addr_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StInit;
            init_addr_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Outputs: RAM clear port in INIT, zero-latency grant in RUN
    always_comb begin
        grant_valid_o   = in_run && pick_valid;
        grant_tag_o     = grant_valid_o ? pick_tag : '0;
        in_read_o       = '0;
        if (grant_valid_o) begin
            in_read_o[pick_tag] = 1'b1;
        end
        mem_init_we_o   = in_init;
        mem_init_addr_o = in_init ? init_addr_q : '0;
        mem_init_data_o = '0;
        init_done_o     = in_run;
    end

`ifdef FLUX_GRANT_CNT_EN
    for (genvar g = 0; g < FLUX; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 hit;

        assign hit = grant_valid_o && (grant_tag_o == TAG_WIDTH'(g));

        // Saturating increment on each grant to this flux
        always_comb begin
            cnt_d = cnt_q;
            if (hit && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Clear has priority over a same-cycle increment
        always_ff @(posedge clk_i) begin
            if (rst_i || cnt_clr_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Scoreboard bench for flux_rr_scheduler (FLUX=4). Stimulus pushes the
// hand-computed expected outputs per cycle; a monitor pops and compares.
module tb_flux_rr_scheduler;

    localparam int unsigned FLUX = 4;
    localparam int unsigned DW   = 18;

    typedef struct packed {
        logic          we;
        logic [1:0]    addr;
        logic [DW-1:0] data;
        logic          gv;
        logic [1:0]    tag;
        logic [3:0]    rd;
        logic          done;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [3:0]    in_empty;
    logic [3:0]    out_full;
    logic          flush;
    logic          cnt_clr;
    logic [3:0]    in_read;
    logic          grant_valid;
    logic [1:0]    grant_tag;
    logic          mem_init_we;
    logic [1:0]    mem_init_addr;
    logic [DW-1:0] mem_init_data;
    logic          init_done;
`ifdef FLUX_GRANT_CNT_EN
    logic [FLUX*16-1:0] grant_cnt;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    flux_rr_scheduler #(
        .FLUX       (FLUX),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_empty_i      (in_empty),
        .out_full_i      (out_full),
        .flush_i         (flush),
`ifdef FLUX_GRANT_CNT_EN
        .cnt_clr_i       (cnt_clr),
        .grant_cnt_o     (grant_cnt),
`endif
        .in_read_o       (in_read),
        .grant_valid_o   (grant_valid),
        .grant_tag_o     (grant_tag),
        .mem_init_we_o   (mem_init_we),
        .mem_init_addr_o (mem_init_addr),
        .mem_init_data_o (mem_init_data),
        .init_done_o     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic we, input logic [1:0] addr, input logic gv,
                                input logic [1:0] tag, input logic [3:0] rd, input logic done);
        exp_t e;
        e.we   = we;
        e.addr = addr;
        e.data = '0;
        e.gv   = gv;
        e.tag  = tag;
        e.rd   = rd;
        e.done = done;
        return e;
    endfunction

    // Monitor: compares the DUT outputs of each scheduled cycle on the falling edge
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {mem_init_we, mem_init_addr, mem_init_data, grant_valid, grant_tag, in_read,
                 init_done};
            n_checks++;
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL cycle%0d: got we=%b addr=%0d data=%0h gv=%b tag=%0d rd=%b done=%b, want we=%b addr=%0d data=%0h gv=%b tag=%0d rd=%b done=%b",
                         cyc, a.we, a.addr, a.data, a.gv, a.tag, a.rd, a.done,
                         e.we, e.addr, e.data, e.gv, e.tag, e.rd, e.done);
            end
        end
    end

    // Drive one cycle of inputs, queue the expected outputs, advance past the edge
    task automatic step(input logic [3:0] emp, input logic [3:0] ful, input logic fl,
                        input logic r, input exp_t e);
        in_empty = emp;
        out_full = ful;
        flush    = fl;
        rst      = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic direct_check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    localparam logic [3:0] ALL = 4'b0000;
    localparam logic [3:0] NF  = 4'b0000;

    initial begin
        rst      = 1'b1;
        in_empty = 4'hF;
        out_full = 4'h0;
        flush    = 1'b0;
        cnt_clr  = 1'b0;
        @(posedge clk);
        #1;

        // Reset held: every output forced low even with eligible fluxes
        step(ALL, NF, 1'b0, 1'b1, mk(0, 0, 0, 0, 4'b0000, 0));
        step(ALL, NF, 1'b0, 1'b1, mk(0, 0, 0, 0, 4'b0000, 0));

        // INIT: four clear writes, no grants although everything is eligible
        for (int i = 0; i < 4; i++) step(ALL, NF, 1'b0, 1'b0, mk(1, 2'(i), 0, 0, 4'b0000, 0));

        // RUN, all eligible: 0,1,2,3,0,1
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 0, 4'b0001, 1));
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 1, 4'b0010, 1));
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 2, 4'b0100, 1));
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 3, 4'b1000, 1));
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 0, 4'b0001, 1));
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 1, 4'b0010, 1));

        // ptr=2, only fluxes 1 and 3 eligible: 3, then 1 (wrap through 0), then 3
        step(4'b0101, NF, 1'b0, 1'b0, mk(0, 0, 1, 3, 4'b1000, 1));
        step(4'b0101, NF, 1'b0, 1'b0, mk(0, 0, 1, 1, 4'b0010, 1));
        step(4'b0101, NF, 1'b0, 1'b0, mk(0, 0, 1, 3, 4'b1000, 1));

        // Flux 2 has data but its output is full, others empty: nothing served
        step(4'b1011, 4'b0100, 1'b0, 1'b0, mk(0, 0, 0, 0, 4'b0000, 1));
        step(4'b1011, 4'b0100, 1'b0, 1'b0, mk(0, 0, 0, 0, 4'b0000, 1));
        // Pointer still 0
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 0, 4'b0001, 1));
        step(4'b1011, 4'b0100, 1'b0, 1'b0, mk(0, 0, 0, 0, 4'b0000, 1));
        // Pointer still 1
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 1, 4'b0010, 1));

        // Flush with a grant in the same cycle: grant 2 completes, ptr becomes 3
        step(ALL, NF, 1'b1, 1'b0, mk(0, 0, 1, 2, 4'b0100, 1));
        // Clear repeats; a flush during INIT does not restart it
        step(ALL, NF, 1'b0, 1'b0, mk(1, 0, 0, 0, 4'b0000, 0));
        step(ALL, NF, 1'b1, 1'b0, mk(1, 1, 0, 0, 4'b0000, 0));
        step(ALL, NF, 1'b0, 1'b0, mk(1, 2, 0, 0, 4'b0000, 0));
        step(ALL, NF, 1'b0, 1'b0, mk(1, 3, 0, 0, 4'b0000, 0));
        // Pointer preserved across the clear
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 3, 4'b1000, 1));
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 0, 4'b0001, 1));

        // Flush again (grants 1), then reset at INIT address 2
        step(ALL, NF, 1'b1, 1'b0, mk(0, 0, 1, 1, 4'b0010, 1));
        step(ALL, NF, 1'b0, 1'b0, mk(1, 0, 0, 0, 4'b0000, 0));
        step(ALL, NF, 1'b0, 1'b0, mk(1, 1, 0, 0, 4'b0000, 0));
        step(ALL, NF, 1'b0, 1'b1, mk(0, 0, 0, 0, 4'b0000, 0));
        for (int i = 0; i < 4; i++) step(ALL, NF, 1'b0, 1'b0, mk(1, 2'(i), 0, 0, 4'b0000, 0));
        // Reset cleared the pointer
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 0, 4'b0001, 1));
        step(ALL, NF, 1'b0, 1'b0, mk(0, 0, 1, 1, 4'b0010, 1));

        // Reset mid-RUN: clear restarts from address 0
        step(ALL, NF, 1'b0, 1'b1, mk(0, 0, 0, 0, 4'b0000, 0));
        for (int i = 0; i < 4; i++) step(ALL, NF, 1'b0, 1'b0, mk(1, 2'(i), 0, 0, 4'b0000, 0));
        step(4'b0111, NF, 1'b0, 1'b0, mk(0, 0, 1, 3, 4'b1000, 1));

`ifdef FLUX_GRANT_CNT_EN
        // Clear counters, then three grants to fluxes 0,1,2 (ptr is 0 after granting 3)
        in_empty = 4'hF;
        cnt_clr  = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr  = 1'b0;
        direct_check("cnt_after_clr", 64'(grant_cnt), 64'h0);
        in_empty = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        direct_check("cnt_three_grants", 64'(grant_cnt), 64'h0000_0001_0001_0001);
        // 70000 grants to flux 0 saturate its counter
        in_empty = 4'b1110;
        repeat (70000) @(posedge clk);
        #1;
        direct_check("cnt_saturate", 64'(grant_cnt[15:0]), 64'hFFFF);
        direct_check("cnt_others", 64'(grant_cnt[63:16]), 64'h0000_0001_0001);
        // Clear wins over a same-cycle grant
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        direct_check("cnt_clr_vs_grant", 64'(grant_cnt), 64'h0);
`endif

        // Let the monitor drain; a stuck queue is a failure
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
